// File: rtl/branch_redirect_unit_pkg.sv
// Shared types and constants for the branch redirect unit.
package bru_pkg;

  typedef enum logic {
    RUN       = 1'b0,
    TRAP_WAIT = 1'b1
  } bru_state_e;

  localparam logic [6:0]  BRANCH_OPCODE = 7'b1100011;
  localparam logic [31:0] PC_STEP       = 32'd4;

endpackage

// File: rtl/branch_redirect_unit_if.sv
// EX-to-fetch redirect bus.
// master drives the EX decision; slave is the PC owner.
// Optional perf counters exist only when BRU_PERF_EN is defined.
interface branch_redirect_unit_if;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        cond_taken;
  logic        ex_is_jump;
  logic [31:0] ex_target;
  logic        stall;
  logic        trap_ack;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_en;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        misalign;
  logic [31:0] bad_addr;
`ifdef BRU_PERF_EN
  logic [31:0] br_count;
  logic [31:0] br_taken_count;
`endif

  modport master (
    output ex_valid, ex_is_branch, cond_taken, ex_is_jump, ex_target, stall, trap_ack,
    input  pc, pc_plus4, fetch_en, flush_if_id, flush_id_ex, misalign, bad_addr
`ifdef BRU_PERF_EN
    , input br_count, br_taken_count
`endif
  );

  modport slave (
    input  ex_valid, ex_is_branch, cond_taken, ex_is_jump, ex_target, stall, trap_ack,
    output pc, pc_plus4, fetch_en, flush_if_id, flush_id_ex, misalign, bad_addr
`ifdef BRU_PERF_EN
    , output br_count, br_taken_count
`endif
  );
endinterface

// File: rtl/branch_redirect_unit.sv
// Fetch-side PC owner: sequential advance, branch/jump redirect,
// pipeline squash and misaligned-target trap.
// Optional feature: BRU_PERF_EN adds branch / taken-branch counters.
module branch_redirect_unit
  import bru_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_redirect_unit_if.slave bus
);

  bru_state_e  state;
  logic [31:0] pc_q;
  logic [31:0] bad_addr_q;
  logic        misalign_q;
  logic        run;
  logic        take;
  logic        bad;

  // EX inputs only matter while running; a trapped unit ignores them.
  assign run  = (state == RUN);
  assign take = run & bus.ex_valid &
                ((bus.ex_is_branch & bus.cond_taken) | bus.ex_is_jump);
  assign bad  = take & (bus.ex_target[1:0] != 2'b00);

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_q + PC_STEP;
  assign bus.fetch_en    = run;
  assign bus.flush_if_id = take;
  assign bus.flush_id_ex = take;
  assign bus.misalign    = misalign_q;
  assign bus.bad_addr    = bad_addr_q;

  // PC / trap FSM: redirect beats stall, trap beats redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      pc_q       <= RESET_PC;
      bad_addr_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bad) begin
            pc_q       <= TRAP_PC;
            bad_addr_q <= bus.ex_target;
            misalign_q <= 1'b1;
            state      <= TRAP_WAIT;
          end else if (take) begin
            pc_q <= bus.ex_target;
          end else if (!bus.stall) begin
            pc_q <= pc_q + PC_STEP;
          end
        end
        TRAP_WAIT: begin
          // pc sits at TRAP_PC; advance resumes the edge after exit
          if (bus.trap_ack) begin
            state      <= RUN;
            misalign_q <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef BRU_PERF_EN
  logic [31:0] br_cnt_q;
  logic [31:0] br_taken_cnt_q;

  assign bus.br_count       = br_cnt_q;
  assign bus.br_taken_count = br_taken_cnt_q;

  // Branch statistics, counted only while running; wrap freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q       <= '0;
      br_taken_cnt_q <= '0;
    end else if (run && bus.ex_valid && bus.ex_is_branch) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (bus.cond_taken) br_taken_cnt_q <= br_taken_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed self-checking bench for branch_redirect_unit.
// Define BRU_PERF_EN to also exercise the branch counters.
module tb_branch_redirect_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  branch_redirect_unit_if bus ();

  branch_redirect_unit #(
    .RESET_PC(32'h0000_0000),
    .TRAP_PC (32'h0000_0100)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one edge, settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ex_valid     = 1'b0;
    bus.ex_is_branch = 1'b0;
    bus.cond_taken   = 1'b0;
    bus.ex_is_jump   = 1'b0;
    bus.ex_target    = '0;
    bus.stall        = 1'b0;
    bus.trap_ack     = 1'b0;
  endtask

  task automatic drive_br(input logic taken, input logic [31:0] tgt);
    bus.ex_valid     = 1'b1;
    bus.ex_is_branch = 1'b1;
    bus.cond_taken   = taken;
    bus.ex_is_jump   = 1'b0;
    bus.ex_target    = tgt;
    #1;
  endtask

  task automatic drive_jmp(input logic [31:0] tgt);
    bus.ex_valid     = 1'b1;
    bus.ex_is_branch = 1'b0;
    bus.cond_taken   = 1'b0;
    bus.ex_is_jump   = 1'b1;
    bus.ex_target    = tgt;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rst_n = 1'b0;
    #12;
    // reset state
    chk("rst_pc",       bus.pc,          32'h0);
    chk("rst_pc4",      bus.pc_plus4,    32'h4);
    chk("rst_fetch",    32'(bus.fetch_en), 32'h1);
    chk("rst_misalign", 32'(bus.misalign), 32'h0);
    chk("rst_bad_addr", bus.bad_addr,    32'h0);
    chk("rst_flush",    32'(bus.flush_if_id | bus.flush_id_ex), 32'h0);
    rst_n = 1'b1;

    // sequential fetch
    step(); chk("seq_pc4",  bus.pc, 32'h4);
    step(); chk("seq_pc8",  bus.pc, 32'h8);
    step(); chk("seq_pc12", bus.pc, 32'hC);
    chk("seq_fetch", 32'(bus.fetch_en), 32'h1);
    chk("seq_flush", 32'({bus.flush_if_id, bus.flush_id_ex}), 32'h0);
    for (int i = 0; i < 5; i++) step();
    chk("seq_pc20", bus.pc, 32'h20);

    // taken branch
    drive_br(1'b1, 32'h80);
    chk("br_flush_ifid", 32'(bus.flush_if_id), 32'h1);
    chk("br_flush_idex", 32'(bus.flush_id_ex), 32'h1);
    step(); idle();
    chk("br_pc80", bus.pc, 32'h80);
    step(); chk("br_pc84", bus.pc, 32'h84);

    // back to 0x20, then not-taken branch
    drive_jmp(32'h20);
    step(); idle();
    chk("jmp_pc20", bus.pc, 32'h20);
    drive_br(1'b0, 32'h80);
    chk("nt_flush", 32'({bus.flush_if_id, bus.flush_id_ex}), 32'h0);
    step(); idle();
    chk("nt_pc24", bus.pc, 32'h24);

    // bubble with jump set never redirects
    drive_jmp(32'h200);
    bus.ex_valid = 1'b0; #1;
    chk("bubble_flush", 32'(bus.flush_if_id), 32'h0);
    step(); idle();
    chk("bubble_pc28", bus.pc, 32'h28);

    // stall
    drive_jmp(32'h40);
    step(); idle();
    chk("stall_pc40", bus.pc, 32'h40);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", bus.pc, 32'h40);
    end
    chk("stall_fetch", 32'(bus.fetch_en), 32'h1);
    bus.stall = 1'b0;
    step(); chk("stall_pc44", bus.pc, 32'h44);
    bus.stall = 1'b1;
    drive_jmp(32'h100);
    chk("stall_jmp_flush", 32'({bus.flush_if_id, bus.flush_id_ex}), 32'h3);
    step(); idle();
    chk("stall_jmp_pc", bus.pc, 32'h100);

    // misaligned trap
    drive_br(1'b1, 32'h82);
    chk("trap_flush", 32'(bus.flush_if_id), 32'h1);
    step(); idle();
    chk("trap_misalign", 32'(bus.misalign), 32'h1);
    chk("trap_bad_addr", bus.bad_addr, 32'h82);
    chk("trap_pc",       bus.pc, 32'h100);
    chk("trap_fetch",    32'(bus.fetch_en), 32'h0);
    drive_br(1'b1, 32'h200);
    chk("trap_ign_flush", 32'({bus.flush_if_id, bus.flush_id_ex}), 32'h0);
    step(); idle();
    chk("trap_ign_pc",   bus.pc, 32'h100);
    chk("trap_ign_bad",  bus.bad_addr, 32'h82);
    bus.trap_ack = 1'b1;
    step(); bus.trap_ack = 1'b0;
    chk("ack_misalign", 32'(bus.misalign), 32'h0);
    chk("ack_pc",       bus.pc, 32'h100);
    chk("ack_fetch",    32'(bus.fetch_en), 32'h1);
    step(); chk("ack_pc104", bus.pc, 32'h104);
    bus.trap_ack = 1'b1;
    step(); bus.trap_ack = 1'b0;
    chk("ack_run_ign", bus.pc, 32'h108);
    chk("ack_run_mis", 32'(bus.misalign), 32'h0);

    // wrap
    drive_jmp(32'hFFFF_FFFC);
    step(); idle();
    chk("wrap_pc",  bus.pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", bus.pc_plus4, 32'h0);
    step(); chk("wrap_pc0", bus.pc, 32'h0);

`ifdef BRU_PERF_EN
    rst_n = 1'b0; #1; rst_n = 1'b1;
    chk("perf_rst_br",  bus.br_count, 32'h0);
    chk("perf_rst_tk",  bus.br_taken_count, 32'h0);
    drive_br(1'b0, 32'h40); step();
    drive_br(1'b1, 32'h40); step();
    drive_br(1'b0, 32'h40); step();
    drive_br(1'b1, 32'h80); step();
    drive_br(1'b0, 32'h40); step();
    idle();
    chk("perf_br",  bus.br_count, 32'd5);
    chk("perf_tk",  bus.br_taken_count, 32'd2);
    #2 rst_n = 1'b0; #1;
    chk("perf_mid_br", bus.br_count, 32'h0);
    chk("perf_mid_tk", bus.br_taken_count, 32'h0);
    chk("perf_mid_pc", bus.pc, 32'h0);
    rst_n = 1'b1;
    step();
`endif

    // asynchronous reset out of TRAP_WAIT
    drive_jmp(32'h3);
    step(); idle();
    chk("pre_rst_mis", 32'(bus.misalign), 32'h1);
    #2 rst_n = 1'b0; #1;
    chk("arst_pc",    bus.pc, 32'h0);
    chk("arst_mis",   32'(bus.misalign), 32'h0);
    chk("arst_bad",   bus.bad_addr, 32'h0);
    chk("arst_fetch", 32'(bus.fetch_en), 32'h1);
    rst_n = 1'b1;
    step(); chk("arst_resume", bus.pc, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
